// File: rtl/fir_axis_out_fifo_if.sv
// ---------------------------------------------------------------------------
// fir_axis_out_fifo_if
//
// AXI-Stream style handshake bundle used on both sides of the FIR output
// buffer. One instance carries the FIR master stream into the FIFO, and a
// second instance carries the buffered stream out to the consumer.
//
// Signals:
//   tvalid  producer -> consumer  beat valid
//   tdata   producer -> consumer  beat payload (pDATA_WIDTH bits)
//   tlast   producer -> consumer  last beat of a frame
//   tready  consumer -> producer  consumer can take the beat
//
// Modports:
//   master  drives tvalid/tdata/tlast and observes tready
//   slave   observes tvalid/tdata/tlast and drives tready
// ---------------------------------------------------------------------------
interface fir_axis_out_fifo_if #(
  parameter int pDATA_WIDTH = 32
) ();

  logic                   tvalid;
  logic [pDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic                   tready;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface : fir_axis_out_fifo_if

// File: rtl/fir_axis_out_fifo.sv
// ---------------------------------------------------------------------------
// fir_axis_out_fifo
//
// Output buffer sitting directly behind the FIR's AXI-Stream master port.
// A small synchronous FIFO absorbs y[i] samples so short back-pressure from
// the consumer does not stall the filter. The popped beats are also counted
// against the programmed frame length: a one-cycle frame_done pulse marks
// the end of every frame, and a sticky len_err reports any disagreement
// between tlast and the programmed length.
//
// Ports:
//   axis_clk     in   clock for all logic
//   axis_rst     in   synchronous, active-high reset
//   s_axis       slave modport  : upstream stream (FIR sm_* signals)
//   m_axis       master modport : downstream stream to the consumer
//   data_length  in   expected samples per frame, 0 = no length checking
//   level        out  current occupancy, 0..DEPTH
//   frame_done   out  one-cycle pulse after the final beat of a frame pops
//   len_err      out  sticky tlast/length mismatch flag
//   err_clr      in   clears len_err (a simultaneous new error wins)
//
// Timing notes:
//   - s_tready is a register computed from the next-state occupancy, so
//     the upstream sees a clean flop output and the FIFO can never be
//     over-filled.
//   - m_tvalid/m_tdata/m_tlast are decoded from registered state only;
//     a beat written in cycle N is visible at the earliest in cycle N+1.
// ---------------------------------------------------------------------------
module fir_axis_out_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int DEPTH       = 8,
  parameter int pCNT_WIDTH  = 10
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst,
  fir_axis_out_fifo_if.slave         s_axis,
  fir_axis_out_fifo_if.master        m_axis,
  input  logic [pCNT_WIDTH-1:0]      data_length,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       frame_done,
  output logic                       len_err,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);      // entry address width
  localparam int EW = pDATA_WIDTH + 1;    // entry = {tlast, tdata}

  // -------------------------------------------------------------------------
  // Pointer / occupancy state
  // -------------------------------------------------------------------------
  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // addresses with differing wrap bits mean full.
  logic [AW:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   level_next;
  logic          s_tready_reg, s_tready_next;

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  assign wr_idx = wr_ptr_reg[AW-1:0];
  assign rd_idx = rd_ptr_reg[AW-1:0];
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);

  // s_tready_reg already accounts for the pending pop, so it is zero
  // whenever the FIFO is full; the extra !full term keeps the storage safe
  // even if that invariant were ever disturbed.
  assign push = s_axis.tvalid && s_tready_reg && !full;
  assign pop  = !empty && m_axis.tready;

  // -------------------------------------------------------------------------
  // Storage: one register per entry, written only when the write pointer
  // addresses it. Entries are not reset; validity is tracked by the
  // pointers alone.
  // -------------------------------------------------------------------------
  logic [EW-1:0] entry_arr [DEPTH];
  logic [EW-1:0] wr_entry;

  assign wr_entry = {s_axis.tlast, s_axis.tdata};

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [EW-1:0] entry_reg;
      logic          entry_we;

      assign entry_we = push && (wr_idx == AW'(gi));

      always_ff @(posedge axis_clk) begin
        if (entry_we) begin
          entry_reg <= wr_entry;
        end
      end

      assign entry_arr[gi] = entry_reg;
    end
  endgenerate

  // First-word-fall-through view of the head entry. The outputs are forced
  // to zero while empty so stale storage never shows up on m_tdata/m_tlast.
  logic [EW-1:0] head_entry;
  logic          head_last;

  assign head_entry = entry_arr[rd_idx];
  assign head_last  = !empty && head_entry[EW-1];

  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = empty ? '0 : head_entry[pDATA_WIDTH-1:0];
  assign m_axis.tlast  = head_last;
  assign s_axis.tready = s_tready_reg;
  assign level         = wr_ptr_reg - rd_ptr_reg;

  // -------------------------------------------------------------------------
  // Next-state occupancy and ready
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    level_next    = wr_ptr_next - rd_ptr_next;
    s_tready_next = (level_next != (AW + 1)'(DEPTH));
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      s_tready_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      s_tready_reg <= s_tready_next;
    end
  end

  // -------------------------------------------------------------------------
  // Frame accounting (advances on pops only)
  // -------------------------------------------------------------------------
  logic [pCNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [pCNT_WIDTH-1:0] cnt_inc;
  logic                  frame_done_reg, frame_done_next;
  logic                  len_err_reg, len_err_next;
  logic                  len_check;
  logic                  at_length;
  logic                  frame_end;
  logic                  err_hit;

  assign cnt_inc   = cnt_reg + 1'b1;
  assign len_check = (data_length != '0);
  assign at_length = len_check && (cnt_inc == data_length);

  // A frame closes on tlast, or on reaching the programmed length even if
  // tlast is missing. Both disagreement directions raise len_err.
  assign frame_end = pop && (head_last || at_length);
  assign err_hit   = pop && len_check &&
                     ((head_last && (cnt_inc != data_length)) ||
                      (at_length && !head_last));

  always_comb begin
    cnt_next        = cnt_reg;
    frame_done_next = frame_end;
    len_err_next    = len_err_reg;
    if (frame_end) begin
      cnt_next = '0;
    end else if (pop) begin
      cnt_next = cnt_inc;   // wraps modulo 2^pCNT_WIDTH when unchecked
    end
    if (err_hit) begin
      len_err_next = 1'b1;  // a new error outranks a same-cycle clear
    end else if (err_clr) begin
      len_err_next = 1'b0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      cnt_reg        <= '0;
      frame_done_reg <= 1'b0;
      len_err_reg    <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      frame_done_reg <= frame_done_next;
      len_err_reg    <= len_err_next;
    end
  end

  assign frame_done = frame_done_reg;
  assign len_err    = len_err_reg;

endmodule : fir_axis_out_fifo

// File: tb/tb_fir_axis_out_fifo.sv
// ---------------------------------------------------------------------------
// tb_fir_axis_out_fifo
//
// Self-checking bench for fir_axis_out_fifo. Inputs are driven and outputs
// sampled on the falling clock edge. A queue-based reference model tracks
// the FIFO contents, the expected ready, frame end pulses and the sticky
// length error from the behavioural rules of the block.
// ---------------------------------------------------------------------------
module tb_fir_axis_out_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 10;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          axis_clk = 1'b0;
  logic          axis_rst = 1'b1;
  logic [CW-1:0] data_length = '0;
  logic [LW-1:0] level;
  logic          frame_done;
  logic          len_err;
  logic          err_clr = 1'b0;

  always #5 axis_clk = ~axis_clk;

  fir_axis_out_fifo_if #(.pDATA_WIDTH(DW)) s_if ();
  fir_axis_out_fifo_if #(.pDATA_WIDTH(DW)) m_if ();

  fir_axis_out_fifo #(
    .pDATA_WIDTH(DW),
    .DEPTH      (DEPTH),
    .pCNT_WIDTH (CW)
  ) dut (
    .axis_clk   (axis_clk),
    .axis_rst   (axis_rst),
    .s_axis     (s_if.slave),
    .m_axis     (m_if.master),
    .data_length(data_length),
    .level      (level),
    .frame_done (frame_done),
    .len_err    (len_err),
    .err_clr    (err_clr)
  );

  int nchecks = 0;
  int nerrs   = 0;

  // Reference model state
  logic [DW:0]   src_q[$];   // beats the upstream still has to deliver
  logic [DW:0]   mq[$];      // beats the FIFO should be holding
  logic [DW-1:0] gen[$];     // every generated payload, in order
  int            fcnt;
  int            npop;
  logic          exp_fd;
  logic          exp_err;
  logic          exp_sready;

  // Drive one clock cycle and advance the model; returns at the next
  // falling edge with the DUT outputs settled for the new cycle.
  task automatic cycle(input logic mready, input logic sen, input logic clr);
    logic          pop, push, fend, ecnd;
    logic [DW:0]   b;
    logic [CW-1:0] n;
    m_if.tready = mready;
    err_clr     = clr;
    s_if.tvalid = sen && (src_q.size() > 0);
    if (src_q.size() > 0) {s_if.tlast, s_if.tdata} = src_q[0];
    pop  = mready && (mq.size() > 0);
    push = s_if.tvalid && exp_sready;
    fend = 1'b0;
    ecnd = 1'b0;
    if (pop) begin
      b    = mq.pop_front();
      n    = CW'(fcnt + 1);
      fend = b[DW] || (data_length != 0 && n == data_length);
      ecnd = (data_length != 0) &&
             ((b[DW] && n != data_length) || (!b[DW] && n == data_length));
      fcnt = fend ? 0 : int'(n);
      npop++;
    end
    if (push) mq.push_back(src_q.pop_front());
    exp_fd     = fend;
    exp_err    = ecnd ? 1'b1 : (clr ? 1'b0 : exp_err);
    exp_sready = (mq.size() < DEPTH);
    @(posedge axis_clk);
    @(negedge axis_clk);
  endtask

  task automatic do_reset();
    axis_rst    = 1'b1;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    err_clr     = 1'b0;
    @(posedge axis_clk);
    @(negedge axis_clk);
    src_q.delete();
    mq.delete();
    gen.delete();
    fcnt       = 0;
    npop       = 0;
    exp_fd     = 1'b0;
    exp_err    = 1'b0;
    exp_sready = 1'b0;
    axis_rst   = 1'b0;
  endtask

  task automatic add_beat(input logic [DW-1:0] d, input logic last);
    src_q.push_back({last, d});
    gen.push_back(d);
  endtask

  task automatic test_reset();
    do_reset();
    nchecks++; if (s_if.tready !== 1'b0) begin nerrs++; $display("FAIL reset_s_tready: got %b expected 0", s_if.tready); end
    nchecks++; if (m_if.tvalid !== 1'b0) begin nerrs++; $display("FAIL reset_m_tvalid: got %b expected 0", m_if.tvalid); end
    nchecks++; if (m_if.tdata !== '0) begin nerrs++; $display("FAIL reset_m_tdata: got %h expected 0", m_if.tdata); end
    nchecks++; if (m_if.tlast !== 1'b0) begin nerrs++; $display("FAIL reset_m_tlast: got %b expected 0", m_if.tlast); end
    nchecks++; if (level !== '0) begin nerrs++; $display("FAIL reset_level: got %0d expected 0", level); end
    nchecks++; if (frame_done !== 1'b0) begin nerrs++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    nchecks++; if (len_err !== 1'b0) begin nerrs++; $display("FAIL reset_len_err: got %b expected 0", len_err); end
    cycle(1'b0, 1'b0, 1'b0);
    nchecks++; if (s_if.tready !== 1'b1) begin nerrs++; $display("FAIL reset_ready_after: got %b expected 1", s_if.tready); end
    $display("test_reset done");
  endtask

  task automatic test_basic_order();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
    do_reset();
    data_length = '0;
    for (int i = 0; i < 3; i++) add_beat(exp_d[i], 1'b0);
    for (int i = 0; i < 10 && src_q.size() > 0; i++) cycle(1'b0, 1'b1, 1'b0);
    nchecks++; if (level !== LW'(3)) begin nerrs++; $display("FAIL basic_level3: got %0d expected 3", level); end
    for (int i = 0; i < 3; i++) begin
      nchecks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h11) begin
        nerrs++; $display("FAIL basic_hold: got v=%b d=%h expected v=1 d=11", m_if.tvalid, m_if.tdata);
      end
      cycle(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      nchecks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp_d[i]) begin
        nerrs++; $display("FAIL basic_pop%0d: got v=%b d=%h expected v=1 d=%h", i, m_if.tvalid, m_if.tdata, exp_d[i]);
      end
      cycle(1'b1, 1'b0, 1'b0);
    end
    nchecks++; if (m_if.tvalid !== 1'b0) begin nerrs++; $display("FAIL basic_empty_valid: got %b expected 0", m_if.tvalid); end
    nchecks++; if (level !== '0) begin nerrs++; $display("FAIL basic_empty_level: got %0d expected 0", level); end
    $display("test_basic_order done");
  endtask

  task automatic test_full();
    do_reset();
    data_length = '0;
    for (int i = 0; i < DEPTH + 1; i++) add_beat($urandom, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0);
    nchecks++; if (level !== LW'(DEPTH)) begin nerrs++; $display("FAIL full_level: got %0d expected %0d", level, DEPTH); end
    nchecks++; if (s_if.tready !== 1'b0) begin nerrs++; $display("FAIL full_ready: got %b expected 0", s_if.tready); end
    nchecks++; if (m_if.tdata !== gen[0]) begin nerrs++; $display("FAIL full_head: got %h expected %h", m_if.tdata, gen[0]); end
    cycle(1'b1, 1'b1, 1'b0);
    nchecks++; if (s_if.tready !== 1'b1 || level !== LW'(DEPTH - 1)) begin
      nerrs++; $display("FAIL full_after_pop: got rdy=%b lvl=%0d expected rdy=1 lvl=%0d", s_if.tready, level, DEPTH - 1);
    end
    cycle(1'b0, 1'b1, 1'b0);
    nchecks++; if (level !== LW'(DEPTH) || s_if.tready !== 1'b0) begin
      nerrs++; $display("FAIL full_ninth: got lvl=%0d rdy=%b expected lvl=%0d rdy=0", level, s_if.tready, DEPTH);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      nchecks++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== gen[k]) begin
        nerrs++; $display("FAIL full_drain%0d: got v=%b d=%h expected v=1 d=%h", k, m_if.tvalid, m_if.tdata, gen[k]);
      end
      cycle(1'b1, 1'b0, 1'b0);
    end
    nchecks++; if (level !== '0) begin nerrs++; $display("FAIL full_drained_level: got %0d expected 0", level); end
    $display("test_full done");
  endtask

  task automatic test_long_frame();
    int stalls = 0, data_bad = 0, fd_bad = 0, err_bad = 0, fd_cnt = 0;
    do_reset();
    data_length = CW'(600);
    for (int i = 0; i < 600; i++) add_beat($urandom, i == 599);
    for (int i = 0; i < 800 && npop < 600; i++) begin
      if (i >= 1 && src_q.size() > 0 && s_if.tready !== 1'b1) stalls++;
      if (m_if.tvalid === 1'b1 && m_if.tdata !== gen[npop]) data_bad++;
      if (frame_done === 1'b1) fd_cnt++;
      if (frame_done !== exp_fd) fd_bad++;
      if (len_err !== exp_err) err_bad++;
      cycle(1'b1, 1'b1, 1'b0);
    end
    nchecks++; if (npop != 600) begin nerrs++; $display("FAIL long_pops: got %0d expected 600", npop); end
    nchecks++; if (stalls != 0) begin nerrs++; $display("FAIL long_stalls: got %0d expected 0", stalls); end
    nchecks++; if (data_bad != 0) begin nerrs++; $display("FAIL long_data: got %0d bad beats expected 0", data_bad); end
    nchecks++; if (fd_bad != 0 || fd_cnt != 0) begin nerrs++; $display("FAIL long_early_done: got %0d/%0d expected 0/0", fd_bad, fd_cnt); end
    nchecks++; if (err_bad != 0) begin nerrs++; $display("FAIL long_err_track: got %0d expected 0", err_bad); end
    nchecks++; if (frame_done !== 1'b1) begin nerrs++; $display("FAIL long_done_pulse: got %b expected 1", frame_done); end
    nchecks++; if (len_err !== 1'b0) begin nerrs++; $display("FAIL long_len_err: got %b expected 0", len_err); end
    cycle(1'b1, 1'b0, 1'b0);
    nchecks++; if (frame_done !== 1'b0) begin nerrs++; $display("FAIL long_done_width: got %b expected 0", frame_done); end
    $display("test_long_frame done");
  endtask

  task automatic test_early_tlast();
    int err_bad = 0, fd_cnt = 0;
    do_reset();
    data_length = CW'(600);
    for (int i = 0; i < 599; i++) add_beat($urandom, i == 598);
    for (int i = 0; i < 800 && npop < 599; i++) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (len_err !== exp_err) err_bad++;
      cycle(1'b1, 1'b1, 1'b0);
    end
    nchecks++; if (npop != 599) begin nerrs++; $display("FAIL early_pops: got %0d expected 599", npop); end
    nchecks++; if (err_bad != 0 || fd_cnt != 0) begin nerrs++; $display("FAIL early_premature: got err=%0d fd=%0d expected 0/0", err_bad, fd_cnt); end
    nchecks++; if (len_err !== 1'b1 || frame_done !== 1'b1) begin
      nerrs++; $display("FAIL early_flags: got err=%b done=%b expected 1/1", len_err, frame_done);
    end
    cycle(1'b1, 1'b0, 1'b0);
    nchecks++; if (len_err !== 1'b1) begin nerrs++; $display("FAIL early_sticky: got %b expected 1", len_err); end
    cycle(1'b1, 1'b0, 1'b1);
    nchecks++; if (len_err !== exp_err || len_err !== 1'b0) begin nerrs++; $display("FAIL early_clear: got %b expected 0", len_err); end
    $display("test_early_tlast done");
  endtask

  task automatic test_random();
    do_reset();
    data_length = '0;
    for (int i = 0; i < 1000; i++) add_beat($urandom, $urandom_range(0, 15) == 0);
    for (int i = 0; i < 8000 && npop < 1000; i++) begin
      nchecks++; if (level !== LW'(mq.size()) || level > LW'(DEPTH)) begin
        nerrs++; $display("FAIL rand_level: got %0d expected %0d", level, mq.size());
      end
      nchecks++; if (s_if.tready !== exp_sready) begin nerrs++; $display("FAIL rand_ready: got %b expected %b", s_if.tready, exp_sready); end
      nchecks++; if (m_if.tvalid !== (mq.size() > 0)) begin nerrs++; $display("FAIL rand_valid: got %b expected %b", m_if.tvalid, mq.size() > 0); end
      if (mq.size() > 0) begin
        nchecks++; if (m_if.tdata !== gen[npop] || m_if.tlast !== mq[0][DW]) begin
          nerrs++; $display("FAIL rand_data: got %h/%b expected %h/%b", m_if.tdata, m_if.tlast, gen[npop], mq[0][DW]);
        end
      end
      nchecks++; if (frame_done !== exp_fd || len_err !== 1'b0) begin
        nerrs++; $display("FAIL rand_flags: got done=%b err=%b expected %b/0", frame_done, len_err, exp_fd);
      end
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0, 1'b0);
    end
    nchecks++; if (npop != 1000) begin nerrs++; $display("FAIL rand_pops: got %0d expected 1000", npop); end
    $display("test_random done");
  endtask

  task automatic test_mid_reset();
    int fd_cnt = 0;
    do_reset();
    data_length = CW'(8);
    for (int i = 0; i < 7; i++) add_beat($urandom, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    nchecks++; if (level !== LW'(5)) begin nerrs++; $display("FAIL mid_level5: got %0d expected 5", level); end
    do_reset();
    nchecks++; if (m_if.tvalid !== 1'b0 || level !== '0) begin
      nerrs++; $display("FAIL mid_after_reset: got v=%b lvl=%0d expected 0/0", m_if.tvalid, level);
    end
    data_length = CW'(4);
    for (int i = 0; i < 4; i++) add_beat($urandom, i == 3);
    for (int i = 0; i < 40 && npop < 4; i++) begin
      if (frame_done === 1'b1) fd_cnt++;
      nchecks++; if (m_if.tvalid === 1'b1 && m_if.tdata !== gen[npop]) begin
        nerrs++; $display("FAIL mid_data: got %h expected %h", m_if.tdata, gen[npop]);
      end
      cycle(1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      if (frame_done === 1'b1) fd_cnt++;
      cycle(1'b1, 1'b0, 1'b0);
    end
    nchecks++; if (fd_cnt != 1) begin nerrs++; $display("FAIL mid_frame_done: got %0d pulses expected 1", fd_cnt); end
    nchecks++; if (len_err !== 1'b0) begin nerrs++; $display("FAIL mid_len_err: got %b expected 0", len_err); end
    $display("test_mid_reset done");
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    test_reset();
    test_basic_order();
    test_full();
    test_long_frame();
    test_early_tlast();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_fir_axis_out_fifo

// File: doc/fir_axis_out_fifo.md
Name: fir_axis_out_fifo

Overview:
- Output buffer stage directly downstream of the FIR AXI-Stream master port (sm_tvalid/sm_tdata/sm_tlast/sm_tready).
- Absorbs y[i] samples in a small synchronous FIFO so the FIR is not stalled by short consumer back-pressure.
- Counts delivered samples against the programmed data length (same value the FIR holds at offset 0x10), flags frame completion and tlast/length mismatches.

Parameters:
- pDATA_WIDTH, 32, width of stream data.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- pCNT_WIDTH, 10, width of sample counter and data_length.

Ports:
- axis_clk  in  1  single clock for all logic.
- axis_rst  in  1  synchronous, active-high reset.
- s_tvalid  in  1  upstream (FIR sm_tvalid) data valid.
- s_tdata  in  pDATA_WIDTH  upstream y[i].
- s_tlast  in  1  upstream last-sample marker.
- s_tready  out  1  FIFO can accept (drives FIR sm_tready).
- m_tvalid  out  1  downstream data valid.
- m_tdata  out  pDATA_WIDTH  head-of-FIFO data.
- m_tlast  out  1  head-of-FIFO last marker.
- m_tready  in  1  downstream ready.
- data_length  in  pCNT_WIDTH  expected samples per frame; 0 disables length checking.
- level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- frame_done  out  1  one-cycle pulse when the final sample of a frame is popped.
- len_err  out  1  sticky mismatch flag.
- err_clr  in  1  clears len_err.

Behaviour:
- Reset: s_tready=0 during the reset cycle, then 1 on the first cycle after reset deasserts. m_tvalid=0, m_tdata=0, m_tlast=0, level=0, frame_done=0, len_err=0. Sample counter=0; read/write pointers=0.
- Reset mid-operation discards all stored entries and the counter. No partial beat survives.
- Storage:
  - Entry = {tlast, tdata}, DEPTH entries.
  - Write/read pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare. Pointers wrap naturally.
- Push: occurs when s_tvalid && s_tready.
  - s_tready = !full, registered, computed from next-state occupancy.
  - Data and tlast are held by upstream until accepted; the FIFO never drops an accepted beat.
- Pop: occurs when m_tvalid && m_tready.
  - m_tvalid = !empty.
  - m_tdata/m_tlast always show the head entry (first-word-fall-through view of storage). While m_tvalid=1 and m_tready=0, these outputs are stable.
- Latency: a beat accepted in cycle N appears on m_tvalid at cycle N+1 at the earliest. There is no combinational bypass from s_* to m_*.
- Simultaneous push and pop:
  - Not full and not empty: both happen; level is unchanged.
  - Empty: only push happens (nothing to pop).
  - Full: s_tready=0, so only pop happens; s_tready rises the next cycle.
- level: updates each cycle by +1 (push only), -1 (pop only) or 0. It never exceeds DEPTH or goes below 0.
- Frame counter (advances on pop only):
  - cnt_next = cnt+1 on each pop.
  - A frame ends on a pop where m_tlast=1, or where cnt_next == data_length with data_length != 0.
  - At frame end: frame_done pulses high in the following cycle, and the counter returns to 0.
- len_err (data_length != 0 only): set in the cycle after a pop where m_tlast=1 and cnt_next != data_length, or where cnt_next == data_length and m_tlast=0.
  - Once set, stays set until err_clr=1 for one cycle.
  - If err_clr and a new error occur in the same cycle, set wins.
- data_length is sampled every pop. Software changes it only while the stream is idle; changes mid-frame are undefined.
- Counter width: pCNT_WIDTH bits, wrapping modulo 2^pCNT_WIDTH when data_length=0 and no tlast arrives.

Test Plan:
- Reset, then push 3 beats (0x11, 0x22, 0x33) with m_tready=0 -> level=3, m_tvalid=1, m_tdata=0x11 stable. Raise m_tready -> 0x11, 0x22, 0x33 appear on consecutive cycles, then m_tvalid=0, level=0.
- Fill with DEPTH=8 beats while m_tready=0 -> s_tready=0 after the 8th accept, and a 9th beat is held (not lost). Pop one -> s_tready=1 next cycle, 9th beat accepted, level back to 8.
- Continuous s_tvalid=1 and m_tready=1 for 600 beats, data_length=600, tlast on beat 600 -> no stalls after the first beat, frame_done pulses exactly once right after beat 600, len_err=0.
- data_length=600, tlast on beat 599 -> len_err=1 after that pop and frame_done pulses. err_clr=1 -> len_err=0 next cycle.
- Random m_tready (50%) with 1000 beats -> output order and data match input exactly, and level never exceeds 8.
- Assert axis_rst with level=5 mid-frame -> next cycle m_tvalid=0, level=0, counter=0. A new 4-beat frame with data_length=4 completes with frame_done pulsing once and len_err=0.
